// File: rtl/mc_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// single-outstanding instruction and data handshakes and a trap-to-HALT path.
module mc_core #(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int unsigned IMEM_WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_valid,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_valid,
    output logic [31:0]           pc,
    output logic                  retire,
    output logic                  halted,
    output logic [1:0]            err
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

    localparam int unsigned WAIT_W = (IMEM_WAIT_MAX < 1) ? 1 : $clog2(IMEM_WAIT_MAX + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ORI = 6'h0D,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    stateT                 state, stateNext;
    logic [1:0]            haltCause;
    logic [31:0]           regFile [32];
    logic [31:0]           ir, rsVal, rtVal, result, pcNext;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [WAIT_W-1:0]     waitCnt;
    logic [4:0]            wbIdx;
    logic                  wbEn, isStore;

    logic [5:0]            opcode, funct;
    logic [4:0]            rs, rt, rd;
    logic [31:0]           simm, zimm, pcPlus4;

    logic                  illegal, sysCall, memOp, storeOp, wrEn;
    logic [4:0]            wrIdx;
    logic [31:0]           aluRes, target;
    logic [ADDR_WIDTH-1:0] effAddr;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign zimm    = {16'h0, ir[15:0]};
    assign pcPlus4 = pc + 32'd4;

    always_comb begin
        illegal = 1'b0;
        sysCall = 1'b0;
        memOp   = 1'b0;
        storeOp = 1'b0;
        wrEn    = 1'b0;
        wrIdx   = rt;
        aluRes  = '0;
        target  = pcPlus4;
        effAddr = ADDR_WIDTH'(rsVal + simm);
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU:    begin wrEn = 1'b1; wrIdx = rd; aluRes = rsVal + rtVal; end
                    FN_SUBU:    begin wrEn = 1'b1; wrIdx = rd; aluRes = rsVal - rtVal; end
                    FN_AND:     begin wrEn = 1'b1; wrIdx = rd; aluRes = rsVal & rtVal; end
                    FN_OR:      begin wrEn = 1'b1; wrIdx = rd; aluRes = rsVal | rtVal; end
                    FN_SLT:     begin wrEn = 1'b1; wrIdx = rd; aluRes = {31'b0, $signed(rsVal) < $signed(rtVal)}; end
                    FN_JR:      target  = rsVal;
                    FN_SYSCALL: sysCall = 1'b1;
                    default:    illegal = 1'b1;
                endcase
            end
            OP_J:     target = {pcPlus4[31:28], ir[25:0], 2'b00};
            OP_JAL:   begin
                target = {pcPlus4[31:28], ir[25:0], 2'b00};
                wrEn   = 1'b1;
                wrIdx  = 5'd31;
                aluRes = pcPlus4;
            end
            OP_BEQ:   if (rsVal == rtVal) target = pcPlus4 + (simm << 2);
            OP_BNE:   if (rsVal != rtVal) target = pcPlus4 + (simm << 2);
            OP_ADDIU: begin wrEn = 1'b1; aluRes = rsVal + simm; end
            OP_SLTI:  begin wrEn = 1'b1; aluRes = {31'b0, $signed(rsVal) < $signed(simm)}; end
            OP_ORI:   begin wrEn = 1'b1; aluRes = rsVal | zimm; end
            OP_LUI:   begin wrEn = 1'b1; aluRes = {ir[15:0], 16'h0}; end
            OP_LW:    begin memOp = 1'b1; wrEn = 1'b1; end
            OP_SW:    begin memOp = 1'b1; storeOp = 1'b1; end
            default:  illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        haltCause = 2'd0;
        case (state)
            FETCH: begin
                if (imem_valid) stateNext = DECODE;
                else if (waitCnt == WAIT_W'(IMEM_WAIT_MAX)) begin
                    stateNext = HALT;
                    haltCause = 2'd3;
                end
            end
            DECODE: stateNext = EXEC;
            EXEC: begin
                if (illegal)                             begin stateNext = HALT; haltCause = 2'd1; end
                else if (sysCall)                        begin stateNext = HALT; haltCause = 2'd0; end
                else if (memOp && effAddr[1:0] != 2'b00) begin stateNext = HALT; haltCause = 2'd2; end
                else if (memOp)                          stateNext = MEM;
                else                                     stateNext = WB;
            end
            MEM:     if (dmem_valid) stateNext = WB;
            WB:      stateNext = FETCH;
            default: stateNext = HALT;
        endcase
    end

    // Reset forces FETCH asynchronously, so the fetch request is gated by rst_n to stay low during reset.
    always_comb begin
        imem_req = rst_n && (state == FETCH);
        dmem_req = (state == MEM);
        dmem_we  = (state == MEM) && isStore;
        retire   = (state == WB);
        halted   = (state == HALT);
    end

    assign imem_addr  = pc[ADDR_WIDTH-1:0];
    assign dmem_addr  = memAddr;
    assign dmem_wdata = rtVal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            rsVal   <= '0;
            rtVal   <= '0;
            result  <= '0;
            pcNext  <= '0;
            memAddr <= '0;
            waitCnt <= '0;
            wbIdx   <= '0;
            wbEn    <= 1'b0;
            isStore <= 1'b0;
            err     <= '0;
            for (int unsigned i = 0; i < 32; i++) regFile[i[4:0]] <= '0;
        end else begin
            if (state != HALT && stateNext == HALT) err <= haltCause;
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        ir      <= imem_rdata;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DECODE: begin
                    rsVal <= regFile[rs];
                    rtVal <= regFile[rt];
                end
                EXEC: begin
                    result  <= aluRes;
                    memAddr <= effAddr;
                    pcNext  <= target;
                    wbEn    <= wrEn;
                    wbIdx   <= wrIdx;
                    isStore <= storeOp;
                end
                MEM: if (dmem_valid && !isStore) result <= dmem_rdata;
                WB: begin
                    pc <= pcNext;
                    if (wbEn && wbIdx != 5'd0) regFile[wbIdx] <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Parameters
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the byte-address width of the instruction and data ports.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter IMEM_WAIT_MAX, default 255; a fetch that waits longer than this many cycles SHALL raise a timeout.

Interface
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request, held high until accepted.
REQ-007 imem_addr  out  ADDR_WIDTH  fetch byte address (PC[ADDR_WIDTH-1:0]).
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 imem_valid  in  1  imem_rdata is valid; completes the fetch.
REQ-010 dmem_req  out  1  data access request.
REQ-011 dmem_we  out  1  1 = store, 0 = load.
REQ-012 dmem_addr  out  ADDR_WIDTH  data byte address.
REQ-013 dmem_wdata  out  32  store data.
REQ-014 dmem_rdata  in  32  load data.
REQ-015 dmem_valid  in  1  completes the data access.
REQ-016 pc  out  32  current PC.
REQ-017 retire  out  1  one-cycle pulse per completed instruction.
REQ-018 halted  out  1  core is stopped.
REQ-019 err  out  2  halt cause: 0 syscall, 1 illegal opcode, 2 misaligned data address, 3 fetch timeout.

Function
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; FETCH exits to DECODE on imem_valid, DECODE to EXEC after 1 cycle, EXEC to MEM (lw/sw) or WB (others) or HALT (trap), MEM to WB on dmem_valid, WB to FETCH after 1 cycle.
REQ-021 The instruction word SHALL be captured in FETCH on the imem_valid cycle; imem_valid SHALL be ignored while imem_req is low.
REQ-022 imem_req and dmem_req SHALL be high, with address and data held stable, from the first cycle of FETCH or MEM until the valid cycle, and low on the cycle after valid.
REQ-023 Supported opcodes: R-type funct addu, subu, and, or, slt, jr, syscall; I/J-type j, jal, beq, bne, addiu, slti, ori, lui, lw, sw; MIPS-I encodings.
REQ-024 Any other opcode or funct SHALL go to HALT with err=1 and no state change.
REQ-025 A register file of 32 x 32 SHALL be internal; $0 SHALL read 0 and writes to $0 SHALL be discarded.
REQ-026 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow traps; slt and slti SHALL compare signed; ori SHALL zero-extend its immediate; addiu and slti SHALL sign-extend theirs; lui SHALL load imm<<16.
REQ-027 Branch target SHALL be PC+4+(sext(imm)<<2); j/jal target SHALL be {PC+4[31:28], imm26, 2'b00}; jal SHALL write PC+4 to $31; jr SHALL load rs.
REQ-028 PC and the register file SHALL update only in WB; retire SHALL pulse in WB.
REQ-029 Zero-wait latency SHALL be 4 cycles per non-memory instruction and 5 cycles per lw/sw.
REQ-030 A lw/sw address with bits [1:0] not equal to 0 SHALL go to HALT with err=2, without asserting dmem_req.
REQ-031 syscall SHALL go to HALT with err=0; FETCH waiting more than IMEM_WAIT_MAX cycles SHALL go to HALT with err=3.
REQ-032 In HALT, halted SHALL be 1, both req outputs SHALL be 0, and the block SHALL leave HALT only by reset.
REQ-033 Address wrap-around SHALL be natural 32-bit for PC; only the low ADDR_WIDTH bits SHALL be driven on the ports.

Reset
REQ-034 While rst_n=0: state FETCH, pc=RESET_PC, all registers 0, imem_req=dmem_req=dmem_we=0, retire=0, halted=0, err=0.
REQ-035 Reset asserted mid-access SHALL drop both req outputs immediately; after release, the first cycle SHALL assert imem_req with imem_addr=RESET_PC.

Verification
REQ-036 addiu $1,$0,5; addu $2,$1,$1 with zero-wait imem -> $2=10, retire pulses at cycles 4 and 8 after reset release.
REQ-037 sw $2,8($0) then lw $3,8($0) with dmem_valid delayed 3 cycles -> dmem_req held 4 cycles with addr 8 stable; $3=10.
REQ-038 beq $0,$0,-1 -> pc returns to the same address every 4 cycles; bne $0,$0 -> pc+4.
REQ-039 jal 0x40 at pc 0x10 -> $31=0x14, pc=0x100; then jr $31 -> pc=0x14.
REQ-040 Opcode 0x3F -> halted=1, err=1, no retire; lw from addr 6 -> err=2, dmem_req never high; imem_valid held low 256 cycles -> err=3.
REQ-041 rst_n pulled low while dmem_req=1 -> dmem_req=0 in the same cycle; after release, imem_addr=RESET_PC and all registers read 0.
